// File: rtl/delay_tap_calibrator.sv
// delay_tap_calibrator
// Sweeps every tap of a clock-buffer delay chain and launches test patterns
// through a launch/capture flop pair at each tap. A per-tap pass mask is built
// from the results. The tap at the centre of the longest contiguous passing
// window becomes best_tap, and tap_sel is driven to it when the sweep ends.
module delay_tap_calibrator #(
    parameter int NUM_TAPS   = 6,   // selectable chain taps (2..16)
    parameter int TAP_W      = 3,   // tap index width, 2^TAP_W >= NUM_TAPS
    parameter int SAMPLES    = 4,   // trials per tap, all must pass
    parameter int SETTLE_CYC = 2,   // idle cycles after a tap change (>= 1)
    parameter int TIMEOUT    = 8    // cycles to wait for capture_valid (>= 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [TAP_W-1:0]    tap_sel,
    output logic                launch,
    output logic                test_d,
    input  logic                capture_valid,
    input  logic                capture_q,
    output logic                busy,
    output logic                done,
    output logic [NUM_TAPS-1:0] pass_mask,
    output logic [TAP_W-1:0]    best_tap,
    output logic                error
);

    // Each counter runs from 0 to N-1, so clog2(N) bits are enough.
    localparam int SMP_W = (SAMPLES > 1)    ? $clog2(SAMPLES)    : 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TMO_W = (TIMEOUT > 1)    ? $clog2(TIMEOUT)    : 1;
    localparam int LEN_W = TAP_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LAUNCH,
        S_WAIT,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t              state_q,      state_d;
    logic [TAP_W-1:0]    tap_q,        tap_d;
    logic [SMP_W-1:0]    sample_q,     sample_d;
    logic [SET_W-1:0]    settle_q,     settle_d;
    logic [TMO_W-1:0]    wait_q,       wait_d;
    logic                trial_ok_q,   trial_ok_d;
    logic [TAP_W-1:0]    tap_sel_q,    tap_sel_d;
    logic                launch_q,     launch_d;
    logic                test_d_q,     test_d_d;
    logic                busy_q,       busy_d;
    logic                done_q,       done_d;
    logic [NUM_TAPS-1:0] pass_mask_q,  pass_mask_d;
    logic [TAP_W-1:0]    best_tap_q,   best_tap_d;
    logic                error_q,      error_d;
    logic [TAP_W-1:0]    cur_start_q,  cur_start_d;
    logic [LEN_W-1:0]    cur_len_q,    cur_len_d;
    logic [TAP_W-1:0]    best_start_q, best_start_d;
    logic [LEN_W-1:0]    best_len_q,   best_len_d;

    // One-hot decode of the tap under test, used to write its pass_mask bit.
    logic [NUM_TAPS-1:0] tap_onehot;
    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_onehot
        assign tap_onehot[gi] = (tap_q == TAP_W'(gi));
    end

    // The run in progress replaces the best run only when it is strictly
    // longer, so the earliest run wins a tie.
    logic             cur_better;
    logic [TAP_W-1:0] fin_start;
    logic [LEN_W-1:0] fin_len;
    logic [LEN_W-1:0] half_len;
    logic [LEN_W-1:0] centre_sum;

    // Close the open run against the best one and locate the window centre.
    always_comb begin
        cur_better = (cur_len_q > best_len_q);
        fin_start  = cur_better ? cur_start_q : best_start_q;
        fin_len    = cur_better ? cur_len_q   : best_len_q;
        half_len   = (fin_len - LEN_W'(1)) >> 1;
        centre_sum = {1'b0, fin_start} + half_len;
    end

    // Next-state and next-output logic for the calibration sequence.
    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        sample_d     = sample_q;
        settle_d     = settle_q;
        wait_d       = wait_q;
        trial_ok_d   = trial_ok_q;
        tap_sel_d    = tap_sel_q;
        launch_d     = 1'b0;
        test_d_d     = test_d_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_mask_d  = pass_mask_q;
        best_tap_d   = best_tap_q;
        error_d      = error_q;
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;

        case (state_q)
            S_IDLE: begin
                // done_q marks the first idle cycle; a start there is dropped.
                if (start && !done_q) begin
                    tap_d        = '0;
                    tap_sel_d    = '0;
                    sample_d     = '0;
                    settle_d     = '0;
                    pass_mask_d  = '0;
                    error_d      = 1'b0;
                    cur_start_d  = '0;
                    cur_len_d    = '0;
                    best_start_d = '0;
                    best_len_d   = '0;
                    test_d_d     = 1'b0;   // first launch toggles this to 1
                    busy_d       = 1'b1;
                    state_d      = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
                    launch_d = 1'b1;
                    test_d_d = ~test_d_q;
                    state_d  = S_LAUNCH;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end

            S_LAUNCH: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // A capture on the final timeout cycle still counts.
                if (capture_valid) begin
                    trial_ok_d = (capture_q == test_d_q);
                    state_d    = S_CHECK;
                end else if (wait_q == TMO_W'(TIMEOUT - 1)) begin
                    trial_ok_d = 1'b0;
                    state_d    = S_CHECK;
                end else begin
                    wait_d = wait_q + TMO_W'(1);
                end
            end

            S_CHECK: begin
                if (trial_ok_q && (sample_q != SMP_W'(SAMPLES - 1))) begin
                    // Same tap, next trial: no settle needed.
                    sample_d = sample_q + SMP_W'(1);
                    launch_d = 1'b1;
                    test_d_d = ~test_d_q;
                    state_d  = S_LAUNCH;
                end else begin
                    // Tap finished, either after all trials or at its first failure.
                    pass_mask_d = (pass_mask_q & ~tap_onehot)
                                | (trial_ok_q ? tap_onehot : '0);
                    if (trial_ok_q) begin
                        if (cur_len_q == '0) begin
                            cur_start_d = tap_q;
                        end
                        cur_len_d = cur_len_q + LEN_W'(1);
                    end else begin
                        if (cur_better) begin
                            best_start_d = cur_start_q;
                            best_len_d   = cur_len_q;
                        end
                        cur_len_d = '0;
                    end

                    if (tap_q == TAP_W'(NUM_TAPS - 1)) begin
                        state_d = S_FINISH;
                    end else begin
                        tap_d     = tap_q + TAP_W'(1);
                        tap_sel_d = tap_q + TAP_W'(1);
                        sample_d  = '0;
                        settle_d  = '0;
                        state_d   = S_SETTLE;
                    end
                end
            end

            S_FINISH: begin
                // A run still open at the last tap is included here.
                best_start_d = fin_start;
                best_len_d   = fin_len;
                if (fin_len == '0) begin
                    best_tap_d = '0;
                    tap_sel_d  = '0;
                    error_d    = 1'b1;
                end else begin
                    best_tap_d = centre_sum[TAP_W-1:0];
                    tap_sel_d  = centre_sum[TAP_W-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and output registers. Reset aborts any run at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tap_q        <= '0;
            sample_q     <= '0;
            settle_q     <= '0;
            wait_q       <= '0;
            trial_ok_q   <= 1'b0;
            tap_sel_q    <= '0;
            launch_q     <= 1'b0;
            test_d_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_mask_q  <= '0;
            best_tap_q   <= '0;
            error_q      <= 1'b0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            sample_q     <= sample_d;
            settle_q     <= settle_d;
            wait_q       <= wait_d;
            trial_ok_q   <= trial_ok_d;
            tap_sel_q    <= tap_sel_d;
            launch_q     <= launch_d;
            test_d_q     <= test_d_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_mask_q  <= pass_mask_d;
            best_tap_q   <= best_tap_d;
            error_q      <= error_d;
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    assign tap_sel   = tap_sel_q;
    assign launch    = launch_q;
    assign test_d    = test_d_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass_mask = pass_mask_q;
    assign best_tap  = best_tap_q;
    assign error     = error_q;

endmodule

// File: tb/tb_delay_tap_calibrator.sv
// Bench for delay_tap_calibrator. A capture responder models the launch/capture
// path. Each tap is given a behaviour and a capture delay. Expected results come
// from a table or from a reference model that scans the per-tap outcome.
module tb_delay_tap_calibrator;

    localparam int NT  = 6;
    localparam int TW  = 3;
    localparam int SMP = 4;
    localparam int TMO = 8;

    // Per-tap behaviour codes
    localparam int M_PASS = 0;   // capture mirrors test_d
    localparam int M_INV  = 1;   // capture inverted on every trial
    localparam int M_NONE = 2;   // capture_valid never asserted
    localparam int M_LATE = 3;   // inverted on the third trial only

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          capture_valid = 1'b0;
    logic          capture_q = 1'b0;
    logic [TW-1:0] tap_sel;
    logic          launch;
    logic          test_d;
    logic          busy;
    logic          done;
    logic [NT-1:0] pass_mask;
    logic [TW-1:0] best_tap;
    logic          error;

    always #5 clk = ~clk;

    delay_tap_calibrator #(
        .NUM_TAPS(NT), .TAP_W(TW), .SAMPLES(SMP), .SETTLE_CYC(2), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tap_sel(tap_sel),
        .launch(launch), .test_d(test_d), .capture_valid(capture_valid),
        .capture_q(capture_q), .busy(busy), .done(done),
        .pass_mask(pass_mask), .best_tap(best_tap), .error(error)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Responder configuration and state
    logic [2*NT-1:0] cfg_modes = '0;
    int              cfg_dly = 2;
    int              pend = 0;
    logic            pend_data = 1'b0;
    int              resp_tap = -1;
    int              resp_trial = 0;
    int              launch_cnt = 0;
    logic            prev_launch = 1'b0;
    int              done_cnt = 0;

    // Capture path: answers launch after cfg_dly cycles, per the tap behaviour.
    initial begin
        int md;
        forever begin
            @(posedge clk);
            #1;
            capture_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    capture_valid = 1'b1;
                    capture_q     = pend_data;
                end
            end
            if (launch === 1'b1) begin
                chk("launch_gap", {31'b0, prev_launch}, 0);
                chk("test_d_alt", {31'b0, test_d}, (launch_cnt % 2 == 0) ? 1 : 0);
                if (int'(tap_sel) != resp_tap) begin
                    resp_tap   = int'(tap_sel);
                    resp_trial = 0;
                end
                md = int'(cfg_modes[2*tap_sel +: 2]);
                if (md == M_NONE) begin
                    pend = 0;
                end else begin
                    pend      = cfg_dly;
                    pend_data = (md == M_INV || (md == M_LATE && resp_trial == 2)) ? ~test_d : test_d;
                end
                resp_trial++;
                launch_cnt++;
            end
            prev_launch = launch;
        end
    end

    // Count done pulses away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
    end

    // Reference model: per-tap outcome from the behaviour rules, then the
    // longest passing window scanned with plain arithmetic.
    function automatic void model(input logic [2*NT-1:0] modes, input int dly,
                                  output logic [NT-1:0] m, output logic [TW-1:0] b,
                                  output logic e, output int nl);
        int md, run, run_s, best_len, best_s;
        m = '0;
        nl = 0;
        for (int i = 0; i < NT; i++) begin
            md = int'(modes[2*i +: 2]);
            if (dly > TMO || md == M_NONE || md == M_INV) nl += 1;
            else if (md == M_LATE) nl += 3;
            else begin
                nl += SMP;
                m[i] = 1'b1;
            end
        end
        best_len = 0; best_s = 0; run = 0; run_s = 0;
        for (int i = 0; i < NT; i++) begin
            if (m[i]) begin
                if (run == 0) run_s = i;
                run++;
                if (run > best_len) begin
                    best_len = run;
                    best_s   = run_s;
                end
            end else begin
                run = 0;
            end
        end
        e = (best_len == 0);
        b = e ? '0 : TW'(best_s + (best_len - 1) / 2);
    endfunction

    // One full calibration: start, wait for done (bounded), compare results.
    task automatic run_case(input string nm, input logic [2*NT-1:0] modes, input int dly,
                            input bit spam, input logic [NT-1:0] em, input logic [TW-1:0] eb,
                            input logic ee, input int el);
        bit got;
        cfg_modes = modes; cfg_dly = dly; pend = 0;
        resp_tap = -1; resp_trial = 0; launch_cnt = 0; done_cnt = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); if (!spam) start = 1'b0;
        chk({nm, "/busy_at_start"}, {31'b0, busy}, 1);
        chk({nm, "/mask_cleared"}, {26'b0, pass_mask}, 0);
        chk({nm, "/error_cleared"}, {31'b0, error}, 0);
        got = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk({nm, "/done_seen"}, {31'b0, got}, 1);
        // In spam mode start stays high through the done cycle.
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk({nm, "/busy_after"}, {31'b0, busy}, 0);
        chk({nm, "/done_pulses"}, done_cnt, 1);
        chk({nm, "/pass_mask"}, {26'b0, pass_mask}, {26'b0, em});
        chk({nm, "/best_tap"}, {29'b0, best_tap}, {29'b0, eb});
        chk({nm, "/error"}, {31'b0, error}, {31'b0, ee});
        chk({nm, "/tap_sel"}, {29'b0, tap_sel}, {29'b0, eb});
        chk({nm, "/launches"}, launch_cnt, el);
        $display("run %s modes=%h dly=%0d mask=%b best=%0d err=%0d launches=%0d",
                 nm, modes, dly, pass_mask, best_tap, error, launch_cnt);
    endtask

    typedef struct {
        logic [2*NT-1:0] modes;
        int              dly;
        logic [NT-1:0]   mask;
        logic [TW-1:0]   best;
        logic            err;
        int              launches;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [NT-1:0]   m_mask;
        logic [TW-1:0]   m_best;
        logic            m_err;
        int              m_nl;
        logic [2*NT-1:0] rmodes;
        int              rdly;
        int              r;
        bit              hit;

        vt[0] = '{12'hAAA, 2, 6'b000000, 3'd0, 1'b1, 6};    // no capture at all
        vt[1] = '{12'h000, 2, 6'b111111, 3'd2, 1'b0, 24};   // all pass
        vt[2] = '{12'h005, 2, 6'b111100, 3'd3, 1'b0, 18};   // taps 0,1 inverted
        vt[3] = '{12'h050, 2, 6'b110011, 3'd0, 1'b0, 18};   // equal runs
        vt[4] = '{12'h000, 8, 6'b111111, 3'd2, 1'b0, 24};   // capture on last wait cycle
        vt[5] = '{12'h000, 9, 6'b000000, 3'd0, 1'b1, 6};    // capture one cycle too late
        vt[6] = '{12'h155, 1, 6'b100000, 3'd5, 1'b0, 9};    // only the last tap
        vt[7] = '{12'h0C0, 3, 6'b110111, 3'd1, 1'b0, 23};   // tap 3 fails on trial 3

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        chk("reset/tap_sel", {29'b0, tap_sel}, 0);
        chk("reset/busy", {31'b0, busy}, 0);
        chk("reset/pass_mask", {26'b0, pass_mask}, 0);
        chk("reset/best_tap", {29'b0, best_tap}, 0);
        chk("reset/misc", {28'b0, launch, test_d, done, error}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_case($sformatf("vec%0d", i), vt[i].modes, vt[i].dly, 1'b0,
                     vt[i].mask, vt[i].best, vt[i].err, vt[i].launches);
        end

        // start held high during the whole run, including the done cycle
        run_case("spam_start", 12'h000, 2, 1'b1, 6'b111111, 3'd2, 1'b0, 24);

        // Reset while tap 3 is waiting for its capture
        cfg_modes = 12'h000; cfg_dly = 2; pend = 0;
        resp_tap = -1; resp_trial = 0; launch_cnt = 0; done_cnt = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (launch === 1'b1 && tap_sel == 3'd3) begin
                hit = 1'b1;
                break;
            end
        end
        chk("midreset/reached_tap3", {31'b0, hit}, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset/tap_sel", {29'b0, tap_sel}, 0);
        chk("midreset/busy", {31'b0, busy}, 0);
        chk("midreset/pass_mask", {26'b0, pass_mask}, 0);
        chk("midreset/best_tap", {29'b0, best_tap}, 0);
        chk("midreset/misc", {28'b0, launch, test_d, done, error}, 0);
        pend = 0;
        repeat (3) @(negedge clk);
        chk("midreset/no_done", done_cnt, 0);
        rst_n = 1'b1;
        $display("run midreset aborted at tap 3, done pulses=%0d", done_cnt);
        run_case("after_reset", 12'h000, 2, 1'b0, 6'b111111, 3'd2, 1'b0, 24);

        // Randomized behaviours against the reference model
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < NT; i++) begin
                r = $urandom_range(0, 7);
                rmodes[2*i +: 2] = (r < 4) ? 2'(M_PASS) : 2'(r - 4);
            end
            rdly = $urandom_range(1, 10);
            model(rmodes, rdly, m_mask, m_best, m_err, m_nl);
            run_case($sformatf("rand%0d", k), rmodes, rdly, 1'b0, m_mask, m_best, m_err, m_nl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_tap_calibrator.md
Name: delay_tap_calibrator

Overview:
- Sequences calibration of a tapped clock-buffer delay chain that feeds a capture flop.
- Sweeps every tap. At each tap it launches test patterns through a launch/capture flop pair and checks the captured data.
- Records a per-tap pass mask and selects the centre of the longest contiguous passing window as the hold/setup-safe tap.
- Sits beside the delay chain and drives its tap-select mux; runs once after reset or on demand.

Parameters:
- NUM_TAPS, 6, number of selectable chain taps (2..16).
- TAP_W, 3, tap index width; must satisfy 2^TAP_W >= NUM_TAPS.
- SAMPLES, 4, launch/capture trials per tap; all must pass for the tap to pass.
- SETTLE_CYC, 2, idle cycles after each tap change before the first launch.
- TIMEOUT, 8, cycles to wait for capture_valid before declaring a trial failed.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin calibration; ignored while busy.
- tap_sel  out  TAP_W  tap select driven to the delay-chain mux.
- launch  out  1  one-cycle pulse that loads test_d into the launch flop.
- test_d  out  1  test pattern bit presented with launch.
- capture_valid  in  1  capture flop result is valid this cycle.
- capture_q  in  1  captured data bit.
- busy  out  1  calibration in progress.
- done  out  1  one-cycle pulse on completion.
- pass_mask  out  NUM_TAPS  bit i = 1 if tap i passed all SAMPLES trials.
- best_tap  out  TAP_W  selected tap; held until the next completion.
- error  out  1  no tap passed in the last run; sticky until the next start.

Behaviour:
- Reset (async, rst_n=0) values:
  - tap_sel=0, launch=0, test_d=0, busy=0, done=0, pass_mask=0, best_tap=0, error=0.
  - FSM returns to IDLE and all counters clear.
  - Reset mid-sweep aborts the run immediately; no done pulse.
- FSM states and transitions:
  - IDLE: start=1 → tap=0, sample=0, clear pass_mask, clear error, clear run trackers, busy=1 → SETTLE.
  - SETTLE: count SETTLE_CYC cycles → LAUNCH.
  - LAUNCH: launch=1 for exactly one cycle; test_d toggles relative to the previous trial (first trial after start uses 1) → WAIT.
  - WAIT:
    - capture_valid=1 → compare capture_q with the held test_d → CHECK.
    - TIMEOUT cycles without capture_valid → trial fails → CHECK.
    - capture_valid in the same cycle as the timeout expiry counts as a valid capture.
  - CHECK:
    - Any failed trial marks the tap as failed; remaining samples for that tap are skipped.
    - Tap still passing and sample < SAMPLES-1 → sample++ → LAUNCH (no re-settle).
    - Otherwise write pass_mask[tap], update run trackers, then:
      - tap < NUM_TAPS-1 → tap++, sample=0 → SETTLE.
      - last tap → FINISH.
  - FINISH:
    - Longest passing run found → best_tap = run_start + (run_len-1)/2 (integer division), tap_sel = best_tap.
    - No passing tap → best_tap=0, tap_sel=0, error=1.
    - done pulses one cycle, busy=0 → IDLE.
- Run tracking:
  - Current run start and length; best run start and length; all lengths TAP_W+1 bits.
  - On a tie in length, the earliest run wins.
  - A run that ends at the last tap is evaluated at FINISH.
- tap_sel equals the current sweep tap while busy and equals best_tap after done.
- Latency per tap, all trials passing: SETTLE_CYC + SAMPLES × (1 launch + capture delay + 1 check).
- start asserted during busy has no effect. start asserted in the same cycle as done is ignored; a restart requires start in IDLE.
- launch is never asserted outside LAUNCH, and never on two consecutive cycles.

Test Plan:
- All taps pass, capture mirrors test_d after 2 cycles:
  - pass_mask=6'b111111, best_tap=2 (start 0, length 6 → 0+5/2), error=0.
  - Exactly one done pulse; busy low afterwards.
- Taps 0,1 fail (inverted capture), taps 2–5 pass:
  - pass_mask=6'b111100, best_tap=3.
  - Each failing tap uses exactly one launch, not 4.
- Two equal runs, pass_mask pattern 6'b110011 (taps 0,1 and 4,5):
  - best_tap=0 (earliest run wins).
- capture_valid never asserted:
  - Every tap times out after 8 cycles; pass_mask=0, error=1, best_tap=0, tap_sel=0.
- Reset mid-sweep: assert rst_n=0 while sweeping tap 3 in WAIT:
  - All outputs return to reset values at once, no done pulse.
  - After release, start reruns the sweep from tap 0.
- start pulsed repeatedly during busy:
  - Ignored; the sweep completes once with the correct mask.
  - A new start in IDLE clears error and pass_mask.
